// File: rtl/serial_pkg.sv
// Shared definitions for the serial-link blocks.
// The FSM state encoding is kept here so sibling serial blocks can reuse it.
package serial_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out serializer with a valid/ready word interface.
// A new word can be taken during the last-bit cycle, so consecutive words stream without a gap.
module piso_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   output logic             dout,
   output logic             dout_valid,
   output logic             frame_done
);

   import serial_pkg::*;

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;

   logic in_shift;
   logic last_bit;
   logic accept;
   logic head_bit;

   assign in_shift = (state_q == SHIFT);
   assign last_bit = in_shift && (cnt_q == LAST);
   assign accept   = data_valid && data_ready;
   // The bit on the line is always the one at the outgoing end of the shift register.
   assign head_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

   assign data_ready = !in_shift || last_bit;
   assign dout_valid = in_shift;
   assign dout       = in_shift && head_bit;
   assign frame_done = last_bit;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      if (accept) begin
         state_d = SHIFT;
         cnt_d   = '0;
         shreg_d = data_in;
      end else if (in_shift) begin
         if (last_bit) begin
            state_d = IDLE;
            cnt_d   = '0;
            shreg_d = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
            if (MSB_FIRST) begin
               shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
               shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shreg_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one MSB-first and one LSB-first instance share the stimulus.
module tb_piso_serializer;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] data_in;
   logic       data_valid;

   logic data_ready_m, dout_m, dout_valid_m, frame_done_m;
   logic data_ready_l, dout_l, dout_valid_l, frame_done_l;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
      .clk        (clk),
      .reset      (reset),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (data_ready_m),
      .dout       (dout_m),
      .dout_valid (dout_valid_m),
      .frame_done (frame_done_m)
   );

   piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
      .clk        (clk),
      .reset      (reset),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (data_ready_l),
      .dout       (dout_l),
      .dout_valid (dout_valid_l),
      .frame_done (frame_done_l)
   );

   task automatic check(input string tag, input logic got, input logic exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_m(input string tag);
      check({tag, " dout"},       dout_m,       1'b0);
      check({tag, " dout_valid"}, dout_valid_m, 1'b0);
      check({tag, " frame_done"}, frame_done_m, 1'b0);
      check({tag, " data_ready"}, data_ready_m, 1'b1);
   endtask

   initial begin
      logic [15:0] stream;
      logic [7:0]  word;

      // Reset held for two edges with a valid word offered: nothing may be taken.
      reset      = 1'b0;
      data_valid = 1'b1;
      data_in    = 8'hAA;
      tick();
      check_idle_m("rst1");
      tick();
      check_idle_m("rst2");
      check("rst2 lsb dout_valid", dout_valid_l, 1'b0);
      reset      = 1'b1;
      data_valid = 1'b0;
      tick();
      check_idle_m("post_rst");

      // Single word 8'hAA, MSB first; data_in changes after acceptance.
      data_in    = 8'hAA;
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      data_in    = 8'h00;
      word       = 8'hAA;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("aa bit%0d dout", i),       dout_m,       word[7-i]);
         check($sformatf("aa bit%0d dout_valid", i), dout_valid_m, 1'b1);
         check($sformatf("aa bit%0d frame_done", i), frame_done_m, (i == 7));
         check($sformatf("aa bit%0d data_ready", i), data_ready_m, (i == 7));
         check($sformatf("aa lsb bit%0d dout", i),   dout_l,       word[i]);
         tick();
      end
      check_idle_m("aa_end");

      // Back-to-back 8'hA5 then 8'h0A with valid held throughout.
      data_in    = 8'hA5;
      data_valid = 1'b1;
      tick();
      data_in = 8'h0A;
      stream  = 16'hA50A;
      for (int i = 0; i < 16; i++) begin
         check($sformatf("b2b bit%0d dout", i),       dout_m,       stream[15-i]);
         check($sformatf("b2b bit%0d dout_valid", i), dout_valid_m, 1'b1);
         check($sformatf("b2b bit%0d frame_done", i), frame_done_m, (i == 7) || (i == 15));
         if (i == 15) data_valid = 1'b0;
         tick();
      end
      check_idle_m("b2b_end");

      // LSB-first order for 8'h0A: 0,1,0,1,0,0,0,0.
      data_in    = 8'h0A;
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      word       = 8'h0A;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("lsb bit%0d dout", i),       dout_l,       word[i]);
         check($sformatf("lsb bit%0d dout_valid", i), dout_valid_l, 1'b1);
         check($sformatf("lsb bit%0d frame_done", i), frame_done_l, (i == 7));
         tick();
      end
      check("lsb_end dout_valid", dout_valid_l, 1'b0);
      check("lsb_end data_ready", data_ready_l, 1'b1);

      // Reset asserted during bit 3 of 8'hFF discards the word.
      data_in    = 8'hFF;
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("ff bit%0d dout", i), dout_m, 1'b1);
         if (i == 3) reset = 1'b0;
         tick();
      end
      check_idle_m("midrst");

      // First edge out of reset accepts 8'hC3; valid for 8'h3C rises at bit 2 and is held.
      reset      = 1'b1;
      data_in    = 8'hC3;
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      stream     = 16'hC33C;
      for (int i = 0; i < 16; i++) begin
         check($sformatf("hold bit%0d dout", i),       dout_m,       stream[15-i]);
         check($sformatf("hold bit%0d dout_valid", i), dout_valid_m, 1'b1);
         check($sformatf("hold bit%0d frame_done", i), frame_done_m, (i == 7) || (i == 15));
         check($sformatf("hold bit%0d data_ready", i), data_ready_m, (i == 7) || (i == 15));
         if (i == 2) begin
            data_valid = 1'b1;
            data_in    = 8'h3C;
         end
         if (i == 8) data_valid = 1'b0;
         tick();
      end
      check_idle_m("hold_end");
      tick();
      check_idle_m("hold_idle");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
